// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master: state encoding and default widths.
package apb_master_pkg;

  localparam int DEF_ADDR_WD = 32;
  localparam int DEF_DATA_WD = 32;
  localparam int DEF_STRB_WD = DEF_DATA_WD / 8;
  localparam int DEF_PROT_WD = 3;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_master_wait_timer.sv
// Wait-cycle timer for the ACCESS phase. Counts cycles with b_pready low,
// saturates instead of wrapping, and flags the cycle that is the last one
// allowed before the transfer must be abandoned.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic b_pclk,
  input  logic b_prst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_WD = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WD-1:0] CNT_MAX   = CNT_WD'(TIMEOUT);
  localparam logic [CNT_WD-1:0] LAST_WAIT = CNT_WD'(TIMEOUT - 1);

  logic [CNT_WD-1:0] count_q;
  logic [CNT_WD-1:0] count_d;

  // Next count: clear wins, otherwise step while enabled and not saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_WD'(1);
    end
  end

  // Counter register.
  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the waits already spent, so reaching TIMEOUT-1 means the
  // current low-ready cycle is the final one tolerated.
  assign expired = (count_q >= LAST_WAIT);

endmodule

// File: rtl/apb_master.sv
// APB master: accepts one command at a time, runs SETUP/ACCESS on the APB
// bus, and returns a registered response. A transfer whose completer never
// raises b_pready is abandoned after TIMEOUT wait cycles with rsp_err set.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_WD = DEF_ADDR_WD,
  parameter int DATA_WD = DEF_DATA_WD,
  parameter int STRB_WD = DEF_STRB_WD,
  parameter int PROT_WD = DEF_PROT_WD,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               b_pclk,
  input  logic               b_prst_n,
  // command channel
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  input  logic [STRB_WD-1:0] cmd_strb,
  input  logic [PROT_WD-1:0] cmd_prot,
  // response channel
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic               rsp_err,
  // APB bus
  output logic               b_psel,
  output logic               b_penable,
  output logic               b_pwrite,
  output logic [ADDR_WD-1:0] b_paddr,
  output logic [DATA_WD-1:0] b_pwdata,
  output logic [PROT_WD-1:0] b_pprot,
  output logic [STRB_WD-1:0] b_pstrb,
  input  logic [DATA_WD-1:0] b_prdata,
  input  logic               b_pready
);

  apb_state_e state_q, state_d;

  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_WD-1:0] paddr_q, paddr_d;
  logic [DATA_WD-1:0] pwdata_q, pwdata_d;
  logic [PROT_WD-1:0] pprot_q, pprot_d;
  logic [STRB_WD-1:0] pstrb_q, pstrb_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATA_WD-1:0] rsp_rdata_q, rsp_rdata_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .b_pclk   (b_pclk),
    .b_prst_n (b_prst_n),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .expired  (timer_expired)
  );

  // Next state and next registered outputs; everything holds unless a phase
  // transition says otherwise.
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pprot_d      = pprot_q;
    pstrb_d      = pstrb_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d     = ST_SETUP;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          pprot_d     = cmd_prot;
          pstrb_d     = cmd_write ? cmd_strb : '0;
          timer_clear = 1'b1;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        timer_enable = ~b_pready;
        if (b_pready) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : b_prdata;
        end else if (timer_expired) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // APB bus output registers.
  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pprot_q   <= '0;
      pstrb_q   <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pprot_q   <= pprot_d;
      pstrb_q   <= pstrb_d;
    end
  end

  // Response channel registers.
  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);

  assign b_psel    = psel_q;
  assign b_penable = penable_q;
  assign b_pwrite  = pwrite_q;
  assign b_paddr   = paddr_q;
  assign b_pwdata  = pwdata_q;
  assign b_pprot   = pprot_q;
  assign b_pstrb   = pstrb_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: the bench plays the APB completer (small memory
// with a planned number of wait cycles) and predicts every cycle of the bus
// and response channels from a transaction-level plan.
module tb_apb_master;

  localparam int ADDR_WD = 32;
  localparam int DATA_WD = 32;
  localparam int STRB_WD = 4;
  localparam int PROT_WD = 3;
  localparam int TIMEOUT = 4;

  logic               b_pclk;
  logic               b_prst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_WD-1:0] cmd_addr;
  logic [DATA_WD-1:0] cmd_wdata;
  logic [STRB_WD-1:0] cmd_strb;
  logic [PROT_WD-1:0] cmd_prot;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_WD-1:0] rsp_rdata;
  logic               rsp_err;
  logic               b_psel;
  logic               b_penable;
  logic               b_pwrite;
  logic [ADDR_WD-1:0] b_paddr;
  logic [DATA_WD-1:0] b_pwdata;
  logic [PROT_WD-1:0] b_pprot;
  logic [STRB_WD-1:0] b_pstrb;
  logic [DATA_WD-1:0] b_prdata;
  logic               b_pready;

  apb_master #(
    .ADDR_WD (ADDR_WD),
    .DATA_WD (DATA_WD),
    .STRB_WD (STRB_WD),
    .PROT_WD (PROT_WD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .b_pclk    (b_pclk),
    .b_prst_n  (b_prst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .b_psel    (b_psel),
    .b_penable (b_penable),
    .b_pwrite  (b_pwrite),
    .b_paddr   (b_paddr),
    .b_pwdata  (b_pwdata),
    .b_pprot   (b_pprot),
    .b_pstrb   (b_pstrb),
    .b_prdata  (b_prdata),
    .b_pready  (b_pready)
  );

  initial begin
    b_pclk = 1'b0;
    forever #5 b_pclk = ~b_pclk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int vectors = 0;
  int miscompares = 0;

  // completer memory, word indexed by addr[5:2]
  logic [31:0] mem [16];

  // reference model: one entry per upcoming bus cycle of the current transfer
  typedef struct {
    bit penable;
    bit pready;
  } cyc_t;

  cyc_t        plan_q[$];
  bit          resp_pending;
  logic [31:0] exp_rdata;
  bit          exp_err;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_strb;
  logic [2:0]  cur_prot;

  // command currently being offered by the stimulus
  bit          offer;
  logic        off_write;
  logic [31:0] off_addr;
  logic [31:0] off_wdata;
  logic [3:0]  off_strb;
  logic [2:0]  off_prot;
  int          off_waits;
  int          resp_delay;
  int          resp_cnt;
  bit          accepted;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelBusy();
    return (plan_q.size() != 0) || resp_pending;
  endfunction

  task automatic modelReset();
    plan_q.delete();
    resp_pending = 1'b0;
    cur_write    = 1'b0;
    cur_addr     = '0;
    cur_wdata    = '0;
    cur_strb     = '0;
    cur_prot     = '0;
  endtask

  // Literal reset values of every output.
  task automatic checkReset();
    compare("rst_psel", b_psel, 0);
    compare("rst_penable", b_penable, 0);
    compare("rst_pwrite", b_pwrite, 0);
    compare("rst_paddr", b_paddr, 0);
    compare("rst_pwdata", b_pwdata, 0);
    compare("rst_pstrb", b_pstrb, 0);
    compare("rst_pprot", b_pprot, 0);
    compare("rst_rsp_valid", rsp_valid, 0);
    compare("rst_rsp_err", rsp_err, 0);
    compare("rst_rsp_rdata", rsp_rdata, 0);
    compare("rst_cmd_ready", cmd_ready, 1);
  endtask

  // Per-cycle comparison of DUT outputs against the model's expectation.
  task automatic checkOutput();
    logic busy;
    busy = modelBusy();
    compare("cmd_ready", cmd_ready, busy ? 0 : 1);
    if (plan_q.size() != 0) begin
      compare("psel", b_psel, 1);
      compare("penable", b_penable, plan_q[0].penable);
      compare("paddr", b_paddr, cur_addr);
      compare("pwrite", b_pwrite, cur_write);
      compare("pwdata", b_pwdata, cur_wdata);
      compare("pstrb", b_pstrb, cur_write ? cur_strb : 4'h0);
      compare("pprot", b_pprot, cur_prot);
      compare("rsp_valid", rsp_valid, 0);
    end else begin
      compare("psel", b_psel, 0);
      compare("penable", b_penable, 0);
      compare("paddr_hold", b_paddr, cur_addr);
      compare("pwdata_hold", b_pwdata, cur_wdata);
      compare("rsp_valid", rsp_valid, resp_pending);
      if (resp_pending) begin
        compare("rsp_rdata", rsp_rdata, exp_rdata);
        compare("rsp_err", rsp_err, exp_err);
      end
    end
  endtask

  // Drive all DUT inputs for the current cycle.
  task automatic driveInputs();
    if (plan_q.size() != 0 && plan_q[0].penable) begin
      b_pready = plan_q[0].pready;
    end else begin
      b_pready = 1'($urandom_range(0, 1));
    end
    b_prdata = b_pready ? mem[b_paddr[5:2]] : $urandom;

    if (offer && !modelBusy()) begin
      cmd_valid = 1'b1;
      cmd_write = off_write;
      cmd_addr  = off_addr;
      cmd_wdata = off_wdata;
      cmd_strb  = off_strb;
      cmd_prot  = off_prot;
    end else begin
      cmd_valid = modelBusy() ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_strb  = 4'($urandom);
      cmd_prot  = 3'($urandom);
    end

    if (resp_pending && plan_q.size() == 0) begin
      rsp_ready = (resp_cnt >= resp_delay);
      resp_cnt++;
    end else begin
      rsp_ready = 1'($urandom_range(0, 1));
      resp_cnt  = 0;
    end
  endtask

  // Build the expected cycle plan and result for an accepted command.
  task automatic acceptCommand();
    int  n;
    bit  ok;
    logic [3:0] idx;
    cur_write = cmd_write;
    cur_addr  = cmd_addr;
    cur_wdata = cmd_wdata;
    cur_strb  = cmd_strb;
    cur_prot  = cmd_prot;
    accepted  = 1'b1;
    ok = (off_waits < TIMEOUT);
    n  = ok ? off_waits + 1 : TIMEOUT;
    plan_q.push_back('{penable: 1'b0, pready: 1'b0});
    for (int k = 0; k < n; k++) begin
      plan_q.push_back('{penable: 1'b1, pready: (ok && k == off_waits)});
    end
    idx = cmd_addr[5:2];
    if (ok) begin
      exp_err = 1'b0;
      if (cmd_write) begin
        exp_rdata = '0;
        for (int b = 0; b < 4; b++) begin
          if (cmd_strb[b]) mem[idx][8*b +: 8] = cmd_wdata[8*b +: 8];
        end
      end else begin
        exp_rdata = mem[idx];
      end
    end else begin
      exp_err   = 1'b1;
      exp_rdata = '0;
    end
  endtask

  // Advance the model across the coming clock edge.
  task automatic advanceModel();
    if (!b_prst_n) return;
    if (plan_q.size() != 0) begin
      void'(plan_q.pop_front());
      if (plan_q.size() == 0) resp_pending = 1'b1;
    end else if (resp_pending) begin
      if (rsp_ready) resp_pending = 1'b0;
    end else if (cmd_valid) begin
      acceptCommand();
    end
  endtask

  task automatic stepCycle();
    checkOutput();
    driveInputs();
    advanceModel();
    @(posedge b_pclk);
    @(negedge b_pclk);
  endtask

  // Run one complete transfer and report what the DUT showed along the way.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [2:0] p,
                               input int waits, input int delay,
                               output int lat, output int pen, output int rv,
                               output logic [31:0] rdata, output logic err,
                               output logic [3:0] strb_seen);
    off_write  = w;
    off_addr   = a;
    off_wdata  = d;
    off_strb   = s;
    off_prot   = p;
    off_waits  = waits;
    resp_delay = delay;
    accepted   = 1'b0;
    offer      = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) stepCycle();
    offer = 1'b0;
    compare("cmd_accept", accepted, 1);
    lat = 0; pen = 0; rv = 0; rdata = '0; err = 1'b0; strb_seen = '0;
    for (int k = 1; k < 200 && modelBusy(); k++) begin
      if (b_psel === 1'b1) strb_seen = strb_seen | b_pstrb;
      if (b_penable === 1'b1) pen++;
      if (rsp_valid === 1'b1) begin
        rv++;
        if (lat == 0) begin
          lat   = k;
          rdata = rsp_rdata;
          err   = rsp_err;
        end
      end
      stepCycle();
    end
    compare("txn_complete", modelBusy(), 0);
  endtask

  task automatic resetMidTransfer();
    off_write  = 1'b0;
    off_addr   = 32'h24;
    off_wdata  = '0;
    off_strb   = 4'hF;
    off_prot   = 3'h0;
    off_waits  = 99;
    resp_delay = 0;
    accepted   = 1'b0;
    offer      = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) stepCycle();
    offer = 1'b0;
    compare("rst_test_accept", accepted, 1);
    stepCycle();
    compare("pre_reset_penable", b_penable, 1);
    #2 b_prst_n = 1'b0;
    #1 checkReset();
    modelReset();
    @(negedge b_pclk);
    stepCycle();
    stepCycle();
    b_prst_n = 1'b1;
    stepCycle();
  endtask

  initial begin : main
    int lat, pen, rv;
    logic [31:0] rdata;
    logic err;
    logic [3:0] strb_seen;

    for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;
    modelReset();
    offer     = 1'b0;
    resp_cnt  = 0;
    accepted  = 1'b0;
    b_prst_n  = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b0;
    b_prdata  = '0;
    b_pready  = 1'b0;

    #3 b_prst_n = 1'b0;
    #1 checkReset();
    @(negedge b_pclk);
    @(negedge b_pclk);
    b_prst_n = 1'b1;
    $display("[TB] reset released, directed transfers");

    // zero-wait write
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'h0, 0, 0, lat, pen, rv, rdata, err, strb_seen);
    compare("wr_latency", lat, 3);
    compare("wr_penable_cycles", pen, 1);
    compare("wr_err", err, 0);
    compare("wr_rdata", rdata, 0);
    compare("wr_strb", strb_seen, 4'hF);

    // read back
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 3'h0, 0, 1, lat, pen, rv, rdata, err, strb_seen);
    compare("rd_latency", lat, 3);
    compare("rd_rdata", rdata, 32'hDEAD_BEEF);
    compare("rd_err", err, 0);
    compare("rd_strb", strb_seen, 0);
    compare("rd_rsp_cycles", rv, 2);

    // three wait states, one short of the timeout
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 3'h5, 3, 0, lat, pen, rv, rdata, err, strb_seen);
    compare("wait3_penable_cycles", pen, 4);
    compare("wait3_latency", lat, 6);
    compare("wait3_rdata", rdata, 32'hDEAD_BEEF);
    compare("wait3_err", err, 0);

    // completer never ready
    applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, 3'h0, 99, 0, lat, pen, rv, rdata, err, strb_seen);
    compare("timeout_penable_cycles", pen, TIMEOUT);
    compare("timeout_latency", lat, 6);
    compare("timeout_err", err, 1);
    compare("timeout_rdata", rdata, 0);

    // partial-strobe write with a slow response consumer
    applyStimulus(1'b1, 32'h20, 32'h1234_5678, 4'b0101, 3'h2, 1, 5, lat, pen, rv, rdata, err, strb_seen);
    compare("slow_rsp_latency", lat, 4);
    compare("slow_rsp_cycles", rv, 6);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 3'h0, 0, 0, lat, pen, rv, rdata, err, strb_seen);
    compare("strobe_merge_rdata", rdata, 32'hA534_0078);

    $display("[TB] reset during ACCESS");
    resetMidTransfer();
    applyStimulus(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 3'h1, 0, 0, lat, pen, rv, rdata, err, strb_seen);
    compare("post_reset_latency", lat, 3);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 150; t++) begin
      int gap;
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 3'($urandom),
                    $urandom_range(0, 6), $urandom_range(0, 3),
                    lat, pen, rv, rdata, err, strb_seen);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
